// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multi-cycle controller: state codes, opcodes,
// mux/ALU encodings and the packed control word driven each cycle.
package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEM_ADDR = 4'd2;
    localparam state_t S_MEM_RD   = 4'd3;
    localparam state_t S_MEM_WB   = 4'd4;
    localparam state_t S_MEM_WR   = 4'd5;
    localparam state_t S_R_EXEC   = 4'd6;
    localparam state_t S_R_WB     = 4'd7;
    localparam state_t S_BRANCH   = 4'd8;
    localparam state_t S_JUMP     = 4'd9;

    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_LW    = 6'd35;
    localparam logic [5:0] OPC_SW    = 6'd43;
    localparam logic [5:0] OPC_BEQ   = 6'd4;
    localparam logic [5:0] OPC_BNE   = 6'd5;
    localparam logic [5:0] OPC_J     = 6'd2;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational Moore decode: maps the current state (plus opcode, Zero and
// MemReady where a state depends on them) to the datapath control word.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
#(
    parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
    parameter logic [5:0] OP_LW    = OPC_LW,
    parameter logic [5:0] OP_SW    = OPC_SW,
    parameter logic [5:0] OP_BEQ   = OPC_BEQ,
    parameter logic [5:0] OP_BNE   = OPC_BNE,
    parameter logic [5:0] OP_J     = OPC_J
) (
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output logic       op_illegal
);

    always_comb begin
        op_illegal = !((opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                       (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J));
    end

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.alu_op     = ALUOP_ADD;
                ctrl.instr_done = op_illegal;
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl.i_or_d   = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.i_or_d     = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRCB_REG;
                ctrl.alu_op     = ALUOP_SUB;
                ctrl.pc_source  = PCSRC_ALUOUT;
                ctrl.instr_done = 1'b1;
                ctrl.pc_en      = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            S_JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_en      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// MIPS multi-cycle main controller: state register, next-state logic and the
// sticky Illegal flag; control outputs come from mips_ctrl_decode.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
    parameter logic [5:0] OP_LW    = OPC_LW,
    parameter logic [5:0] OP_SW    = OPC_SW,
    parameter logic [5:0] OP_BEQ   = OPC_BEQ,
    parameter logic [5:0] OP_BNE   = OPC_BNE,
    parameter logic [5:0] OP_J     = OPC_J
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       Illegal
);

    state_t state_q, state_d;
    logic   illegal_q;
    logic   op_illegal;
    ctrl_t  ctrl, ctrl_out;

    mips_ctrl_decode #(
        .OP_RTYPE (OP_RTYPE),
        .OP_LW    (OP_LW),
        .OP_SW    (OP_SW),
        .OP_BEQ   (OP_BEQ),
        .OP_BNE   (OP_BNE),
        .OP_J     (OP_J)
    ) u_decode (
        .state      (state_q),
        .opcode     (opcode),
        .zero       (Zero),
        .mem_ready  (MemReady),
        .ctrl       (ctrl),
        .op_illegal (op_illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (MemReady) state_d = S_DECODE;
            S_DECODE: begin
                if ((opcode == OP_LW) || (opcode == OP_SW)) state_d = S_MEM_ADDR;
                else if (opcode == OP_RTYPE)                state_d = S_R_EXEC;
                else if ((opcode == OP_BEQ) || (opcode == OP_BNE)) state_d = S_BRANCH;
                else if (opcode == OP_J)                    state_d = S_JUMP;
                else                                        state_d = S_FETCH;
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD :
                                  (opcode == OP_SW) ? S_MEM_WR : S_FETCH;
            S_MEM_RD:   if (MemReady) state_d = S_MEM_WB;
            S_MEM_WB:   state_d = S_FETCH;
            S_MEM_WR:   if (MemReady) state_d = S_FETCH;
            S_R_EXEC:   state_d = S_R_WB;
            S_R_WB:     state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_DECODE) && op_illegal) illegal_q <= 1'b1;
        end
    end

    // Reset silences every strobe so an aborted access cannot write.
    assign ctrl_out = RESET ? '0 : ctrl;

    assign PCEn      = ctrl_out.pc_en;
    assign IorD      = ctrl_out.i_or_d;
    assign MemRead   = ctrl_out.mem_read;
    assign MemWrite  = ctrl_out.mem_write;
    assign IRWrite   = ctrl_out.ir_write;
    assign RegDst    = ctrl_out.reg_dst;
    assign MemtoReg  = ctrl_out.mem_to_reg;
    assign RegWrite  = ctrl_out.reg_write;
    assign ALUSrcA   = ctrl_out.alu_src_a;
    assign ALUSrcB   = ctrl_out.alu_src_b;
    assign ALUOp     = ctrl_out.alu_op;
    assign PCSource  = ctrl_out.pc_source;
    assign InstrDone = ctrl_out.instr_done;
    assign Illegal   = illegal_q & ~RESET;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: each cycle's full output vector is
// compared against hand-written per-state constants.
module tb_mips_multicycle_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [5:0] opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       InstrDone, Illegal;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .opcode    (opcode),
        .Zero      (Zero),
        .MemReady  (MemReady),
        .PCEn      (PCEn),
        .IorD      (IorD),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .RegDst    (RegDst),
        .MemtoReg  (MemtoReg),
        .RegWrite  (RegWrite),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .PCSource  (PCSource),
        .InstrDone (InstrDone),
        .Illegal   (Illegal)
    );

    always #5 CLK = ~CLK;

    logic [16:0] outs;
    assign outs = {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                   ALUSrcB, ALUOp, PCSource, InstrDone, Illegal};

    // Bit order: PCEn IorD MemRead MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
    //            ALUSrcB ALUOp PCSource InstrDone Illegal
    localparam logic [16:0] E_ZERO       = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] E_FETCH_RDY  = 17'b1_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] E_FETCH_WAIT = 17'b0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [16:0] E_DECODE     = 17'b0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [16:0] E_DEC_ILL    = 17'b0_0_0_0_0_0_0_0_0_11_00_00_1_0;
    localparam logic [16:0] E_MEM_ADDR   = 17'b0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [16:0] E_MEM_RD     = 17'b0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] E_MEM_WB     = 17'b0_0_0_0_0_0_1_1_0_00_00_00_1_0;
    localparam logic [16:0] E_MEMWR_WAIT = 17'b0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [16:0] E_MEMWR_RDY  = 17'b0_1_0_1_0_0_0_0_0_00_00_00_1_0;
    localparam logic [16:0] E_R_EXEC     = 17'b0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [16:0] E_R_WB       = 17'b0_0_0_0_0_1_0_1_0_00_00_00_1_0;
    localparam logic [16:0] E_BR_TAKEN   = 17'b1_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [16:0] E_BR_NOT     = 17'b0_0_0_0_0_0_0_0_1_00_01_01_1_0;
    localparam logic [16:0] E_JUMP       = 17'b1_0_0_0_0_0_0_0_0_00_00_10_1_0;
    localparam logic [16:0] ILL          = 17'b0_0_0_0_0_0_0_0_0_00_00_00_0_1;

    // Drive one cycle's inputs, check the combinational outputs, then clock.
    task automatic step(input logic rst, input logic [5:0] op, input logic z, input logic rdy,
                        input logic [16:0] exp, input string tag);
        RESET    = rst;
        opcode   = op;
        Zero     = z;
        MemReady = rdy;
        #1;
        total++;
        assert (outs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
        @(posedge CLK);
        #1;
    endtask

    // Strobe exclusivity holds every cycle regardless of sequence.
    always @(negedge CLK) begin
        total++;
        assert (!(MemRead && MemWrite) && !(RegWrite && PCEn))
        else begin
            bad++;
            $error("FAIL strobe_excl observed rd=%b wr=%b rw=%b pcen=%b expected no overlap",
                   MemRead, MemWrite, RegWrite, PCEn);
        end
    end

    initial begin
        RESET = 1'b1; opcode = 6'd0; Zero = 1'b0; MemReady = 1'b0;
        @(posedge CLK);
        #1;
        step(1'b1, 6'd0, 1'b0, 1'b1, E_ZERO, "reset_outputs");

        // R-type
        step(1'b0, 6'd0, 1'b0, 1'b1, E_FETCH_RDY, "rt_fetch");
        step(1'b0, 6'd0, 1'b0, 1'b1, E_DECODE,    "rt_decode");
        step(1'b0, 6'd0, 1'b0, 1'b1, E_R_EXEC,    "rt_exec");
        step(1'b0, 6'd0, 1'b0, 1'b1, E_R_WB,      "rt_wb");

        // LW with two wait cycles in MEM_RD
        step(1'b0, 6'd35, 1'b0, 1'b1, E_FETCH_RDY, "lw_fetch");
        step(1'b0, 6'd35, 1'b0, 1'b1, E_DECODE,    "lw_decode");
        step(1'b0, 6'd35, 1'b0, 1'b1, E_MEM_ADDR,  "lw_addr");
        step(1'b0, 6'd35, 1'b0, 1'b0, E_MEM_RD,    "lw_rd_wait1");
        step(1'b0, 6'd35, 1'b0, 1'b0, E_MEM_RD,    "lw_rd_wait2");
        step(1'b0, 6'd35, 1'b0, 1'b1, E_MEM_RD,    "lw_rd_done");
        step(1'b0, 6'd35, 1'b0, 1'b1, E_MEM_WB,    "lw_wb");

        // BEQ / BNE, both Zero values
        step(1'b0, 6'd4, 1'b1, 1'b1, E_FETCH_RDY, "beq_t_fetch");
        step(1'b0, 6'd4, 1'b1, 1'b1, E_DECODE,    "beq_t_decode");
        step(1'b0, 6'd4, 1'b1, 1'b1, E_BR_TAKEN,  "beq_taken");
        step(1'b0, 6'd4, 1'b0, 1'b1, E_FETCH_RDY, "beq_n_fetch");
        step(1'b0, 6'd4, 1'b0, 1'b1, E_DECODE,    "beq_n_decode");
        step(1'b0, 6'd4, 1'b0, 1'b1, E_BR_NOT,    "beq_not");
        step(1'b0, 6'd5, 1'b1, 1'b1, E_FETCH_RDY, "bne_z1_fetch");
        step(1'b0, 6'd5, 1'b1, 1'b1, E_DECODE,    "bne_z1_decode");
        step(1'b0, 6'd5, 1'b1, 1'b1, E_BR_NOT,    "bne_not");
        step(1'b0, 6'd5, 1'b0, 1'b1, E_FETCH_RDY, "bne_z0_fetch");
        step(1'b0, 6'd5, 1'b0, 1'b1, E_DECODE,    "bne_z0_decode");
        step(1'b0, 6'd5, 1'b0, 1'b1, E_BR_TAKEN,  "bne_taken");

        // Illegal opcode, then a SW with the sticky flag visible
        step(1'b0, 6'd8, 1'b0, 1'b1, E_FETCH_RDY, "ill_fetch");
        step(1'b0, 6'd8, 1'b0, 1'b1, E_DEC_ILL,   "ill_decode");
        step(1'b0, 6'd43, 1'b0, 1'b1, E_FETCH_RDY | ILL, "sw_fetch");
        step(1'b0, 6'd43, 1'b0, 1'b1, E_DECODE | ILL,    "sw_decode");
        step(1'b0, 6'd43, 1'b0, 1'b1, E_MEM_ADDR | ILL,  "sw_addr");
        step(1'b0, 6'd43, 1'b0, 1'b1, E_MEMWR_RDY | ILL, "sw_wr");

        // SW aborted by reset while stalled in MEM_WR
        step(1'b0, 6'd43, 1'b0, 1'b1, E_FETCH_RDY | ILL,  "sw2_fetch");
        step(1'b0, 6'd43, 1'b0, 1'b1, E_DECODE | ILL,     "sw2_decode");
        step(1'b0, 6'd43, 1'b0, 1'b1, E_MEM_ADDR | ILL,   "sw2_addr");
        step(1'b0, 6'd43, 1'b0, 1'b0, E_MEMWR_WAIT | ILL, "sw2_wr_wait");
        step(1'b1, 6'd43, 1'b0, 1'b0, E_ZERO,             "sw2_reset");

        // J with FETCH stalled 3 cycles; Illegal is clear after reset
        step(1'b0, 6'd2, 1'b0, 1'b0, E_FETCH_WAIT, "j_fetch_wait1");
        step(1'b0, 6'd2, 1'b0, 1'b0, E_FETCH_WAIT, "j_fetch_wait2");
        step(1'b0, 6'd2, 1'b0, 1'b0, E_FETCH_WAIT, "j_fetch_wait3");
        step(1'b0, 6'd2, 1'b0, 1'b1, E_FETCH_RDY,  "j_fetch");
        step(1'b0, 6'd2, 1'b0, 1'b1, E_DECODE,     "j_decode");
        step(1'b0, 6'd2, 1'b0, 1'b1, E_JUMP,       "j_jump");
        step(1'b0, 6'd0, 1'b0, 1'b0, E_FETCH_WAIT, "after_j_fetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
